parallel_ntt_router: RTL and testbench

- Parametrised host-side control and routing block for a cluster of NUM_PROC NTT processors.
- Generalises the fixed 4-processor top into an N-way router:
  - demuxes host writes to a selected processor;
  - muxes processor read data back to the host;
  - generates a single-cycle start pulse.
- Adds a run-tracking FSM (busy/done from per-processor done flags), access blocking while running, and sticky error reporting.
- Sits between the AXIS host adapter and the processor array; processors attach through flattened buses.

---
 rtl/parallel_ntt_router.sv | 149 ++++++++++++++
 tb/tb_parallel_ntt_router.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_ntt_router.sv
// Host-side router for a cluster of NUM_PROC NTT processors: write demux, read-return mux,
// start pulse generation, run tracking (busy/done) and sticky error reporting.
module parallel_ntt_router #(
    parameter int NUM_PROC = 4,
    parameter int DATA_W   = 32,
    parameter int PIDX_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       start,
    input  logic [DATA_W-1:0]          s_processor_din,
    input  logic [PIDX_W-1:0]          s_processor_num,
    input  logic                       s_processor_din_valid,
    input  logic [PIDX_W-1:0]          m_processor_num,
    input  logic                       m_processor_num_valid,
    output logic [DATA_W-1:0]          m_processor_dout,
    output logic                       m_processor_dout_valid,
    output logic [DATA_W-1:0]          proc_din,
    output logic [NUM_PROC-1:0]        proc_din_valid,
    output logic [NUM_PROC-1:0]        proc_read_valid,
    input  logic [NUM_PROC*DATA_W-1:0] proc_dout,
    input  logic [NUM_PROC-1:0]        proc_dout_valid,
    output logic                       proc_start,
    input  logic [NUM_PROC-1:0]        proc_done,
    output logic                       busy,
    output logic                       done,
    output logic [2:0]                 err,
    input  logic                       err_clr
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [PIDX_W:0] NUM_PROC_L = (PIDX_W + 1)'(NUM_PROC);

    state_t              state, state_nxt;
    logic                start_reg;
    logic                start_armed;
    logic                rise;
    logic                all_done;
    logic                start_pulse_nxt;
    logic [NUM_PROC-1:0] done_seen, done_seen_nxt, seen_now;

    logic                wr_bad, wr_blocked, rd_bad, rd_blocked;
    logic [NUM_PROC-1:0] wr_en, rd_en;
    logic [DATA_W-1:0]   ret_data;
    logic                ret_valid, ret_collision;
    logic [2:0]          err_new;

    function automatic logic [NUM_PROC-1:0] one_hot(input logic [PIDX_W-1:0] idx);
        logic [NUM_PROC-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_PROC; i++)
            oh[i] = (idx == PIDX_W'(i));
        return oh;
    endfunction

    // A level held high across reset must not look like a fresh edge, so the
    // edge detector only arms after it has sampled start once out of reset.
    assign rise     = start & ~start_reg & start_armed;
    assign seen_now = done_seen | proc_done;
    assign all_done = (state == RUN) && (&seen_now);

    always_comb begin
        state_nxt       = state;
        done_seen_nxt   = done_seen;
        start_pulse_nxt = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    start_pulse_nxt = 1'b1;
                    done_seen_nxt   = '0;
                    state_nxt       = RUN;
                end
            end
            RUN: begin
                done_seen_nxt = seen_now;
                if (all_done) begin
                    state_nxt = IDLE;
                    done      = rst_b;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Host access decode: out-of-range indices and accesses during a run are dropped.
    always_comb begin
        wr_bad     = s_processor_din_valid & ({1'b0, s_processor_num} >= NUM_PROC_L);
        wr_blocked = s_processor_din_valid & busy;
        rd_bad     = m_processor_num_valid & ({1'b0, m_processor_num} >= NUM_PROC_L);
        rd_blocked = m_processor_num_valid & busy;
        wr_en      = '0;
        rd_en      = '0;
        if (s_processor_din_valid && !wr_bad && !wr_blocked)
            wr_en = one_hot(s_processor_num);
        if (m_processor_num_valid && !rd_bad && !rd_blocked)
            rd_en = one_hot(m_processor_num);
    end

    // Lowest-index processor wins the return path; more than one claimant is a collision.
    always_comb begin
        ret_data      = '0;
        ret_valid     = |proc_dout_valid;
        ret_collision = (proc_dout_valid & (proc_dout_valid - NUM_PROC'(1))) != '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (proc_dout_valid[i])
                ret_data = proc_dout[i*DATA_W +: DATA_W];
        end
    end

    assign err_new = {ret_collision,
                      wr_blocked | rd_blocked | (rise & (state == RUN)),
                      wr_bad | rd_bad};

    // NOTE: every register here uses <= so all of them update from pre-edge values
    // together; the reset branch is synchronous, so it lives inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state                  <= IDLE;
            done_seen              <= '0;
            start_reg              <= 1'b0;
            start_armed            <= 1'b0;
            proc_start             <= 1'b0;
            proc_din               <= '0;
            proc_din_valid         <= '0;
            proc_read_valid        <= '0;
            m_processor_dout       <= '0;
            m_processor_dout_valid <= 1'b0;
            err                    <= '0;
        end else begin
            state                  <= state_nxt;
            done_seen              <= done_seen_nxt;
            start_reg              <= start;
            start_armed            <= 1'b1;
            proc_start             <= start_pulse_nxt;
            proc_din               <= s_processor_din;
            proc_din_valid         <= wr_en;
            proc_read_valid        <= rd_en;
            m_processor_dout       <= ret_data;
            m_processor_dout_valid <= ret_valid;
            err                    <= (err_clr ? 3'b000 : err) | err_new;
        end
    end

endmodule

// File: tb/tb_parallel_ntt_router.sv
// Bench for parallel_ntt_router: a 4-way and a 3-way instance share host stimulus and are
// compared every cycle against a cycle-level reference model; directed steps follow the test plan.
module tb_parallel_ntt_router;

    logic         clk;
    logic         rst_b;
    logic         start;
    logic [31:0]  s_din;
    logic [1:0]   s_num;
    logic         s_valid;
    logic [1:0]   m_num;
    logic         m_valid;
    logic [127:0] proc_dout;
    logic [3:0]   proc_dout_valid;
    logic [3:0]   proc_done;
    logic         err_clr;

    logic [31:0] o4_mdout, o4_din, o3_mdout, o3_din;
    logic        o4_mv, o4_ps, o4_busy, o4_done, o3_mv, o3_ps, o3_busy, o3_done;
    logic [3:0]  o4_dv, o4_rv;
    logic [2:0]  o3_dv, o3_rv;
    logic [2:0]  o4_err, o3_err;

    int errors = 0;
    int checks = 0;

    parallel_ntt_router #(.NUM_PROC(4), .DATA_W(32), .PIDX_W(2)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start),
        .s_processor_din(s_din), .s_processor_num(s_num), .s_processor_din_valid(s_valid),
        .m_processor_num(m_num), .m_processor_num_valid(m_valid),
        .m_processor_dout(o4_mdout), .m_processor_dout_valid(o4_mv),
        .proc_din(o4_din), .proc_din_valid(o4_dv), .proc_read_valid(o4_rv),
        .proc_dout(proc_dout), .proc_dout_valid(proc_dout_valid),
        .proc_start(o4_ps), .proc_done(proc_done),
        .busy(o4_busy), .done(o4_done), .err(o4_err), .err_clr(err_clr)
    );

    parallel_ntt_router #(.NUM_PROC(3), .DATA_W(32), .PIDX_W(2)) dut3 (
        .clk(clk), .rst_b(rst_b), .start(start),
        .s_processor_din(s_din), .s_processor_num(s_num), .s_processor_din_valid(s_valid),
        .m_processor_num(m_num), .m_processor_num_valid(m_valid),
        .m_processor_dout(o3_mdout), .m_processor_dout_valid(o3_mv),
        .proc_din(o3_din), .proc_din_valid(o3_dv), .proc_read_valid(o3_rv),
        .proc_dout(proc_dout[95:0]), .proc_dout_valid(proc_dout_valid[2:0]),
        .proc_start(o3_ps), .proc_done(proc_done[2:0]),
        .busy(o3_busy), .done(o3_done), .err(o3_err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, index 0 = 4-way instance, index 1 = 3-way instance.
    int          np[2] = '{4, 3};
    bit          model_ok = 0;
    bit          m_run[2], m_prev[2], m_armed[2], m_ps[2], m_mv[2];
    logic [31:0] m_seen[2], m_err[2], m_dv[2], m_rv[2], m_md[2], m_din[2];
    logic        neg_busy4, neg_done4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(int k);
        return (32'd1 << np[k]) - 32'd1;
    endfunction

    function automatic int popcount(logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] msk, pd, pv, e;
            bit rise, all, bsy;
            if (!rst_b) begin
                m_run[k] = 0; m_prev[k] = 0; m_armed[k] = 0; m_ps[k] = 0; m_mv[k] = 0;
                m_seen[k] = 0; m_err[k] = 0; m_dv[k] = 0; m_rv[k] = 0; m_md[k] = 0; m_din[k] = 0;
                continue;
            end
            msk  = mask_of(k);
            pd   = {28'd0, proc_done} & msk;
            pv   = {28'd0, proc_dout_valid} & msk;
            rise = start && !m_prev[k] && m_armed[k];
            all  = m_run[k] && ((m_seen[k] | pd) == msk);
            bsy  = m_run[k] && !all;
            e    = 0;
            m_dv[k] = 0;
            if (s_valid) begin
                if (int'(s_num) >= np[k]) e |= 1;
                if (bsy) e |= 2;
                if (int'(s_num) < np[k] && !bsy) m_dv[k] = 32'd1 << s_num;
            end
            m_rv[k] = 0;
            if (m_valid) begin
                if (int'(m_num) >= np[k]) e |= 1;
                if (bsy) e |= 2;
                if (int'(m_num) < np[k] && !bsy) m_rv[k] = 32'd1 << m_num;
            end
            m_md[k] = 0;
            m_mv[k] = 0;
            for (int i = np[k] - 1; i >= 0; i--)
                if (pv[i]) begin m_md[k] = proc_dout[i*32 +: 32]; m_mv[k] = 1; end
            if (popcount(pv) > 1) e |= 4;
            if (rise && m_run[k]) e |= 2;
            m_ps[k] = !m_run[k] && rise;
            if (!m_run[k] && rise) begin
                m_run[k] = 1; m_seen[k] = 0;
            end else if (m_run[k]) begin
                if (all) m_run[k] = 0;
                else m_seen[k] = m_seen[k] | pd;
            end
            m_err[k]   = (err_clr ? 32'd0 : m_err[k]) | e;
            m_prev[k]  = start;
            m_armed[k] = 1;
            m_din[k]   = s_din;
        end
        if (!rst_b) model_ok = 1;
    endtask

    task automatic check_regs(int k, logic [31:0] din, logic [3:0] dv, logic [3:0] rv,
                              logic [31:0] md, logic mv, logic ps, logic [2:0] er);
        check($sformatf("proc_din[%0d]", k), din, m_din[k]);
        check($sformatf("proc_din_valid[%0d]", k), dv, m_dv[k]);
        check($sformatf("proc_read_valid[%0d]", k), rv, m_rv[k]);
        check($sformatf("m_dout[%0d]", k), md, m_md[k]);
        check($sformatf("m_dout_valid[%0d]", k), mv, m_mv[k]);
        check($sformatf("proc_start[%0d]", k), ps, m_ps[k]);
        check($sformatf("err[%0d]", k), er, m_err[k]);
    endtask

    task automatic cycle();
        @(negedge clk);
        neg_busy4 = o4_busy;
        neg_done4 = o4_done;
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] msk;
                bit all;
                msk = mask_of(k);
                all = m_run[k] && ((m_seen[k] | ({28'd0, proc_done} & msk)) == msk);
                check($sformatf("busy[%0d]", k), k == 0 ? o4_busy : o3_busy, m_run[k] && !all);
                check($sformatf("done[%0d]", k), k == 0 ? o4_done : o3_done, rst_b && all);
            end
        end
        @(posedge clk);
        model_update();
        #1;
        check_regs(0, o4_din, o4_dv, o4_rv, o4_mdout, o4_mv, o4_ps, o4_err);
        check_regs(1, o3_din, {1'b0, o3_dv}, {1'b0, o3_rv}, o3_mdout, o3_mv, o3_ps, o3_err);
    endtask

    initial begin
        rst_b = 0; start = 1; s_din = 32'h0BAD_0001; s_num = 2; s_valid = 1;
        m_num = 1; m_valid = 1; proc_dout = '0; proc_dout_valid = '0; proc_done = '0; err_clr = 0;
        #1;

        // Reset held with start high and strobes active.
        repeat (3) cycle();
        check("rst_din_valid", o4_dv, 4'b0000);
        check("rst_busy", neg_busy4, 1'b0);
        rst_b = 1; s_valid = 0; m_valid = 0;
        repeat (3) cycle();
        check("no_start_after_rst", o4_ps, 1'b0);

        // Load.
        start = 0; s_din = 32'hDEADBEEF; s_num = 2; s_valid = 1;
        cycle();
        check("load_din", o4_din, 32'hDEADBEEF);
        check("load_valid", o4_dv, 4'b0100);
        s_valid = 0;
        cycle();
        check("load_valid_drop", o4_dv, 4'b0000);

        // Readback.
        m_num = 3; m_valid = 1;
        cycle();
        check("read_req", o4_rv, 4'b1000);
        m_valid = 0; proc_dout = {32'h0000_1234, 96'd0}; proc_dout_valid = 4'b1000;
        cycle();
        check("read_data", o4_mdout, 32'h1234);
        check("read_valid", o4_mv, 1'b1);
        proc_dout_valid = 0; err_clr = 1;
        cycle();
        err_clr = 0;

        // Run: start pulse, done in order 0,2,1,3.
        start = 1;
        cycle();
        check("start_pulse", o4_ps, 1'b1);
        cycle();
        check("start_single", o4_ps, 1'b0);
        check("run_busy", neg_busy4, 1'b1);
        proc_done = 4'b0001; cycle();
        proc_done = 4'b0100; cycle();
        proc_done = 4'b0010; cycle();
        proc_done = 4'b1000; cycle();
        check("run_done", neg_done4, 1'b1);
        check("run_done_busy", neg_busy4, 1'b0);
        proc_done = 0;
        cycle();
        check("idle_busy", neg_busy4, 1'b0);
        check("no_restart", o4_ps, 1'b0);

        // Access while busy.
        start = 0; cycle();
        start = 1; cycle(); cycle();
        start = 0; cycle();
        start = 1; s_num = 1; s_valid = 1; s_din = 32'hCAFE_F00D;
        cycle();
        check("busy_write_drop", o4_dv, 4'b0000);
        check("busy_err", o4_err, 3'b010);
        s_valid = 0; err_clr = 1;
        cycle();
        check("err_clear", o4_err, 3'b000);
        err_clr = 0; proc_done = 4'hF; cycle();
        proc_done = 0; start = 0; cycle();

        // Errors on the 3-way instance.
        s_num = 3; s_valid = 1;
        cycle();
        check("np3_bad_en", o3_dv, 3'b000);
        check("np3_bad_err", o3_err[0], 1'b1);
        s_valid = 0;
        proc_dout = {32'h0, 32'h5A5A_5A5A, 32'h A5A5_A5A5, 32'h0}; proc_dout_valid = 4'b0110;
        cycle();
        check("np3_coll_data", o3_mdout, 32'hA5A5_A5A5);
        check("np3_coll_err", o3_err[2], 1'b1);
        proc_dout_valid = 0; err_clr = 1; cycle(); err_clr = 0;

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst_b           = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            s_din           = $urandom;
            s_num           = 2'($urandom_range(0, 3));
            s_valid         = 1'($urandom_range(0, 1));
            m_num           = 2'($urandom_range(0, 3));
            m_valid         = 1'($urandom_range(0, 1));
            proc_dout       = {$urandom, $urandom, $urandom, $urandom};
            proc_dout_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            proc_done       = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            err_clr         = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
